// File: rtl/packet_builder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : packet_builder                                               |
// | Description : Latches a packet request from the connection FSM, fetches an |
// |               optional payload word, computes a one's-complement checksum  |
// |               and streams the packet big-endian over a valid/ready port.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module packet_builder #(
  parameter int         ADDR_W    = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              readyout,
  input  logic              control,
  input  logic [31:0]       SEQout,
  input  logic [31:0]       ACKout,
  input  logic [8:0]        flagsout,
  input  logic [31:0]       ISN,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              packetsent,
  output logic              busy,
  output logic              dropped
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT_MEM = 3'd2,
    S_CALC     = 3'd3,
    S_SEND     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  // Index of the last byte: 13-byte control packets, 17-byte data packets.
  localparam logic [4:0] c_LAST_CTRL = 5'd12;
  localparam logic [4:0] c_LAST_DATA = 5'd16;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_seq;
  logic [31:0] r_ack;
  logic [8:0]  r_flags;
  logic        r_ctrl;
  logic [31:0] r_payload;
  logic [15:0] r_csum;
  logic [4:0]  r_cnt;
  logic        r_dropped;

  logic [15:0] w_fhalf;
  logic [15:0] w_sum;
  logic [31:0] w_addr_full;
  logic [4:0]  w_last_idx;
  logic        w_accept;
  logic        w_last_accept;
  logic        w_start;
  logic [7:0]  w_byte;

  // 16-bit one's-complement add with the end-around carry folded back in.
  // The folded result cannot carry again (max 0xFFFE + 1).
  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  // Bit 15 of the flag halfword marks a data packet.
  assign w_fhalf       = {~r_ctrl, 6'd0, r_flags};
  assign w_addr_full   = r_seq - ISN;
  assign w_last_idx    = r_ctrl ? c_LAST_CTRL : c_LAST_DATA;
  assign w_accept      = (r_state == S_SEND) && tx_ready;
  assign w_last_accept = w_accept && (r_cnt == w_last_idx);
  assign w_start       = (r_state == S_IDLE) && readyout;

  // Checksum over the latched header fields, plus payload for data packets.
  always_comb begin
    w_sum = 16'h0000;
    w_sum = ones_add(w_sum, r_seq[31:16]);
    w_sum = ones_add(w_sum, r_seq[15:0]);
    w_sum = ones_add(w_sum, r_ack[31:16]);
    w_sum = ones_add(w_sum, r_ack[15:0]);
    w_sum = ones_add(w_sum, w_fhalf);
    if (!r_ctrl) begin
      w_sum = ones_add(w_sum, r_payload[31:16]);
      w_sum = ones_add(w_sum, r_payload[15:0]);
    end
  end

  // Byte selector: the checksum follows the flags directly for control packets.
  always_comb begin
    w_byte = 8'h00;
    case (r_cnt)
      5'd0:    w_byte = SYNC_BYTE;
      5'd1:    w_byte = r_seq[31:24];
      5'd2:    w_byte = r_seq[23:16];
      5'd3:    w_byte = r_seq[15:8];
      5'd4:    w_byte = r_seq[7:0];
      5'd5:    w_byte = r_ack[31:24];
      5'd6:    w_byte = r_ack[23:16];
      5'd7:    w_byte = r_ack[15:8];
      5'd8:    w_byte = r_ack[7:0];
      5'd9:    w_byte = w_fhalf[15:8];
      5'd10:   w_byte = w_fhalf[7:0];
      5'd11:   w_byte = r_ctrl ? r_csum[15:8] : r_payload[31:24];
      5'd12:   w_byte = r_ctrl ? r_csum[7:0]  : r_payload[23:16];
      5'd13:   w_byte = r_payload[15:8];
      5'd14:   w_byte = r_payload[7:0];
      5'd15:   w_byte = r_csum[15:8];
      5'd16:   w_byte = r_csum[7:0];
      default: w_byte = 8'h00;
    endcase
  end

  // State register; reset aborts any packet in flight immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded outputs; outputs are idle values by default.
  always_comb begin
    w_next     = r_state;
    mem_addr   = '0;
    mem_rd     = 1'b0;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    packetsent = 1'b0;
    busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (readyout) begin
          w_next = control ? S_CALC : S_FETCH;
        end
      end
      S_FETCH: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = w_addr_full[ADDR_W-1:0];
        w_next   = S_WAIT_MEM;
      end
      S_WAIT_MEM: begin
        busy   = 1'b1;
        w_next = S_CALC;
      end
      S_CALC: begin
        busy   = 1'b1;
        w_next = S_SEND;
      end
      S_SEND: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = w_byte;
        if (w_last_accept) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        packetsent = 1'b1;
        w_next     = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Request latch: fields are captured once so later input changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seq   <= 32'h0;
      r_ack   <= 32'h0;
      r_flags <= 9'h0;
      r_ctrl  <= 1'b0;
    end else if (w_start) begin
      r_seq   <= SEQout;
      r_ack   <= ACKout;
      r_flags <= flagsout;
      r_ctrl  <= control;
    end
  end

  // Payload capture; read data arrives the cycle after the fetch strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_payload <= 32'h0;
    end else if (w_start) begin
      r_payload <= 32'h0;
    end else if (r_state == S_WAIT_MEM) begin
      r_payload <= mem_data;
    end
  end

  // Checksum register, written once all summed fields are stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_csum <= 16'h0;
    end else if (r_state == S_CALC) begin
      r_csum <= ~w_sum;
    end
  end

  // Byte counter advances only on an accepted handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= 5'd0;
    end else if (w_start || (r_state == S_DONE)) begin
      r_cnt <= 5'd0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 5'd1;
    end
  end

  // Sticky drop flag for requests arriving outside IDLE (including DONE).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dropped <= 1'b0;
    end else if (readyout && (r_state != S_IDLE)) begin
      r_dropped <= 1'b1;
    end
  end

  assign dropped = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_packet_builder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_packet_builder                                            |
// | Description : Scoreboard bench for packet_builder: expected bytes are      |
// |               queued when a request is issued and popped on handshakes.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_packet_builder;

  logic        clk;
  logic        reset_n;
  logic        readyout;
  logic        control;
  logic [31:0] seq_in;
  logic [31:0] ack_in;
  logic [8:0]  flags_in;
  logic [31:0] isn;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        packetsent;
  logic        busy;
  logic        dropped;

  int          n_checks;
  int          n_err;
  int          cyc;
  int          req_cyc;
  int          first_cyc;
  int          ps_cnt;
  int          rd_cnt;
  int          acc_cnt;
  logic [15:0] rd_addr;
  logic [31:0] mem_word;
  bit          rand_ready;
  logic [7:0]  exp_q[$];

  logic        prev_valid;
  logic        prev_vnr;
  logic [7:0]  prev_data;

  packet_builder #(
    .ADDR_W    (16),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .readyout   (readyout),
    .control    (control),
    .SEQout     (seq_in),
    .ACKout     (ack_in),
    .flagsout   (flags_in),
    .ISN        (isn),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .packetsent (packetsent),
    .busy       (busy),
    .dropped    (dropped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Send buffer: data appears one cycle after the strobe, junk otherwise.
  always @(posedge clk) mem_data <= mem_rd ? mem_word : 32'hBAD0BAD0;

  // Transmitter ready: held high, or random when backpressure is enabled.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference packet: checksum via 32-bit accumulate then fold.
  task automatic push_packet(input bit ctl, input logic [31:0] s, input logic [31:0] a,
                             input logic [8:0] fl, input logic [31:0] p);
    logic [15:0] f;
    logic [31:0] acc;
    logic [15:0] c;
    f   = {~ctl, 6'd0, fl};
    acc = {16'd0, s[31:16]} + {16'd0, s[15:0]} + {16'd0, a[31:16]} + {16'd0, a[15:0]} + {16'd0, f};
    if (!ctl) acc = acc + {16'd0, p[31:16]} + {16'd0, p[15:0]};
    acc = {16'd0, acc[15:0]} + {16'd0, acc[31:16]};
    acc = {16'd0, acc[15:0]} + {16'd0, acc[31:16]};
    c   = ~acc[15:0];
    exp_q.push_back(8'hA5);
    for (int i = 3; i >= 0; i--) exp_q.push_back(s[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) exp_q.push_back(a[i*8 +: 8]);
    exp_q.push_back(f[15:8]);
    exp_q.push_back(f[7:0]);
    if (!ctl) for (int i = 3; i >= 0; i--) exp_q.push_back(p[i*8 +: 8]);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[7:0]);
  endtask

  // Issue one readyout pulse, queue its bytes, then scramble the live inputs.
  task automatic req(input bit ctl, input logic [31:0] s, input logic [31:0] a,
                     input logic [8:0] fl, input logic [31:0] i_isn, input logic [31:0] p);
    @(posedge clk);
    #1;
    control  = ctl;
    seq_in   = s;
    ack_in   = a;
    flags_in = fl;
    isn      = i_isn;
    mem_word = p;
    readyout = 1'b1;
    req_cyc  = cyc;
    push_packet(ctl, s, a, fl, p);
    @(posedge clk);
    #1;
    readyout = 1'b0;
    control  = ~ctl;
    seq_in   = $urandom;
    ack_in   = $urandom;
    flags_in = 9'($urandom);
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (packetsent) begin
        seen = 1'b1;
        break;
      end
    end
    chk("packetsent_seen", 32'(seen), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd0);
    chk("tx_valid_in_done", 32'(tx_valid), 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);
    @(negedge clk);
  endtask

  // Monitor: scoreboard pop on handshake, hold checks, strobe/pulse counting.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
      prev_vnr   = 1'b0;
      prev_data  = 8'h00;
    end else begin
      if (prev_vnr) begin
        chk("hold_valid", 32'(tx_valid), 32'd1);
        chk("hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && !prev_valid) first_cyc = cyc;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) chk("extra_byte", exp_q.size(), 32'd1);
        else chk("byte", 32'(tx_data), 32'(exp_q.pop_front()));
        acc_cnt++;
      end
      if (packetsent) ps_cnt++;
      if (mem_rd) begin
        rd_cnt++;
        rd_addr = mem_addr;
      end
      prev_valid = tx_valid;
      prev_vnr   = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic clr_counts();
    ps_cnt  = 0;
    rd_cnt  = 0;
    acc_cnt = 0;
    rd_addr = 16'h0;
  endtask

  initial begin
    int ps0;
    n_checks = 0; n_err = 0; cyc = 0; req_cyc = 0; first_cyc = 0;
    rand_ready = 1'b0;
    reset_n = 1'b0; readyout = 1'b0; control = 1'b0;
    seq_in = 32'h0; ack_in = 32'h0; flags_in = 9'h0; isn = 32'h0; mem_word = 32'h0;
    clr_counts();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dropped", 32'(dropped), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Control packet, ready held high.
    clr_counts();
    req(1'b1, 32'h00000001, 32'h0, 9'h012, 32'h0, 32'h0);
    chk("ctrl_busy_set", 32'(busy), 32'd1);
    wait_done(60);
    chk("ctrl_latency", 32'(first_cyc - req_cyc), 32'd2);
    chk("ctrl_packetsent_cnt", ps_cnt, 32'd1);
    chk("ctrl_no_mem_rd", rd_cnt, 32'd0);
    chk("ctrl_bytes", acc_cnt, 32'd13);

    // Data packet.
    clr_counts();
    req(1'b0, 32'h00000105, 32'h00000010, 9'h010, 32'h00000100, 32'hDEADBEEF);
    wait_done(60);
    chk("data_latency", 32'(first_cyc - req_cyc), 32'd4);
    chk("data_mem_rd_cnt", rd_cnt, 32'd1);
    chk("data_mem_addr", 32'(rd_addr), 32'h5);
    chk("data_bytes", acc_cnt, 32'd17);

    // Same data packet under random backpressure.
    clr_counts();
    rand_ready = 1'b1;
    req(1'b0, 32'h00000105, 32'h00000010, 9'h010, 32'h00000100, 32'hDEADBEEF);
    wait_done(500);
    rand_ready = 1'b0;
    chk("bp_packetsent_cnt", ps_cnt, 32'd1);
    chk("bp_mem_rd_cnt", rd_cnt, 32'd1);
    chk("bp_bytes", acc_cnt, 32'd17);

    // Second request during SEND is dropped and leaves the packet intact.
    clr_counts();
    chk("pre_collision_dropped", 32'(dropped), 32'd0);
    req(1'b0, 32'h12345678, 32'h9ABCDEF0, 9'h111, 32'h12340000, 32'hCAFEF00D);
    repeat (6) @(posedge clk);
    #1;
    control = 1'b1; seq_in = 32'h55555555; readyout = 1'b1;
    @(posedge clk);
    #1;
    readyout = 1'b0;
    wait_done(80);
    chk("coll_dropped", 32'(dropped), 32'd1);
    chk("coll_packetsent_cnt", ps_cnt, 32'd1);
    chk("coll_mem_addr", 32'(rd_addr), 32'h5678);
    repeat (5) @(posedge clk);
    #1;
    chk("coll_dropped_sticky", 32'(dropped), 32'd1);

    // Reset in the middle of a packet.
    clr_counts();
    req(1'b0, 32'h00000105, 32'h00000010, 9'h010, 32'h00000100, 32'hDEADBEEF);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt >= 6) break;
    end
    chk("mid_bytes_before_reset", 32'(acc_cnt >= 6), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_packetsent", 32'(packetsent), 32'd0);
    chk("mid_rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_dropped", 32'(dropped), 32'd0);
    exp_q.delete();
    ps0 = ps_cnt;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("mid_no_packetsent", ps_cnt, ps0);
    chk("mid_no_tx_valid", 32'(tx_valid), 32'd0);
    clr_counts();
    req(1'b1, 32'hA0B0C0D0, 32'h01020304, 9'h101, 32'h0, 32'h0);
    wait_done(60);
    chk("post_rst_packetsent_cnt", ps_cnt, 32'd1);
    chk("post_rst_bytes", acc_cnt, 32'd13);

    // Address wrap and checksum carry folding.
    clr_counts();
    req(1'b0, 32'h0000FFFF, 32'hFFFFFFFF, 9'h000, 32'h00010000, 32'hFFFFFFFF);
    wait_done(60);
    chk("wrap_mem_addr", 32'(rd_addr), 32'hFFFF);
    chk("wrap_bytes", acc_cnt, 32'd17);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
